// File: rtl/sm_seq_multiplier.sv
// Sequential shift-add multiplier for signed-magnitude operands.
// One partial product is added per RUN cycle; the signed-magnitude result
// (sign in MSB, never -0) is registered on the RUN->DONE transition, so it is
// valid while done is high and holds until the next result or reset.
module sm_seq_multiplier #(
  parameter int MAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W:0]   multiplicand,
  input  logic [MAG_W:0]   multiplier,
  output logic [2*MAG_W:0] product,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int CW = (MAG_W > 1) ? $clog2(MAG_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // operands captured at start; a is pre-widened so it can be shifted in place
  typedef struct packed {
    logic                 sign;
    logic [2*MAG_W-1:0]   a;
    logic [MAG_W-1:0]     b;
  } op_t;

  state_t             state, state_nxt;
  op_t                op;
  logic [2*MAG_W-1:0] acc, acc_nxt;
  logic [CW-1:0]      count;
  logic               load, step, last;

  assign last    = (count == CW'(MAG_W - 1));
  assign acc_nxt = acc + (op.b[count] ? (op.a << count) : '0);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state, datapath controls and status outputs
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, shift-add accumulation and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
      zero    <= 1'b0;
    end else begin
      if (load) begin
        op.sign <= multiplicand[MAG_W] ^ multiplier[MAG_W];
        op.a    <= {{MAG_W{1'b0}}, multiplicand[MAG_W-1:0]};
        op.b    <= multiplier[MAG_W-1:0];
        acc     <= '0;
        count   <= '0;
      end
      if (step) begin
        acc   <= acc_nxt;
        count <= count + CW'(1);
        if (last) begin
          // zero magnitude always reported as +0
          product <= {op.sign & (acc_nxt != '0), acc_nxt};
          zero    <= (acc_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_seq_multiplier.sv
// Bench for sm_seq_multiplier: a cycle-level behavioural model (operation
// countdown plus plain integer multiply) checked every cycle, directed
// literal cases, and a randomized start/operand/reset phase.
module tb_sm_seq_multiplier;
  localparam int MW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [MW:0]     multiplicand, multiplier;
  logic [2*MW:0]   product;
  logic            busy, done, zero;

  int tests = 0;
  int fails = 0;

  sm_seq_multiplier #(.MAG_W(MW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  // signed-magnitude product straight from arithmetic
  function automatic logic [2*MW:0] sm_mul(input logic [MW:0] a, input logic [MW:0] b);
    int unsigned m;
    logic [2*MW:0] r;
    m = int'(a[MW-1:0]) * int'(b[MW-1:0]);
    r[2*MW-1:0] = m[2*MW-1:0];
    r[2*MW] = (a[MW] ^ b[MW]) && (m != 0);
    return r;
  endfunction

  // model: an op occupies the unit for 3 cycles after its start edge,
  // the last of which presents the result with done
  int            remain = 0;
  bit            mvalid = 0;
  logic [MW:0]   ma, mb;
  logic [2*MW:0] exp_p;
  logic          exp_z;

  always @(posedge clk) begin
    if (rst) begin
      mvalid = 1;
      remain = 0;
      exp_p  = '0;
      exp_z  = 1'b0;
    end else if (mvalid) begin
      if (remain == 0) begin
        if (start) begin
          ma = multiplicand;
          mb = multiplier;
          remain = MW + 1;
        end
      end else begin
        remain = remain - 1;
        if (remain == 1) begin
          exp_p = sm_mul(ma, mb);
          exp_z = (exp_p[2*MW-1:0] == '0);
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (mvalid) begin
      tests++;
      if (product !== exp_p || zero !== exp_z || busy !== (remain != 0) || done !== (remain == 1)) begin
        fails++;
        $display("FAIL model t=%0t: product=%b zero=%b busy=%b done=%b, want product=%b zero=%b busy=%b done=%b",
                 $time, product, zero, busy, done, exp_p, exp_z, (remain != 0), (remain == 1));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // one operation with literal expectations for result and latency
  task automatic run_op(input string name, input logic [MW:0] a, input logic [MW:0] b,
                        input logic [2*MW:0] want_p, input logic want_z);
    int n;
    wait_idle();
    check({name, "_model"}, 32'(sm_mul(a, b)), 32'(want_p));
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = MW'($urandom);
    multiplier   = MW'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 10);
    check({name, "_latency"}, 32'(n), 32'(MW + 1));
    check({name, "_product"}, 32'(product), 32'(want_p));
    check({name, "_zero"}, {31'd0, zero}, {31'd0, want_z});
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, product, busy, done, zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("p9",      3'b011, 3'b011, 5'b01001, 1'b0);
    run_op("n6",      3'b111, 3'b010, 5'b10110, 1'b0);
    run_op("p1",      3'b101, 3'b101, 5'b00001, 1'b0);
    run_op("z_pos",   3'b000, 3'b111, 5'b00000, 1'b1);
    run_op("z_negz",  3'b100, 3'b110, 5'b00000, 1'b1);
    run_op("n3",      3'b011, 3'b101, 5'b10011, 1'b0);

    // second start during RUN must be ignored
    wait_idle();
    multiplicand = 3'b001; multiplier = 3'b010; start = 1'b1;
    @(negedge clk);
    multiplicand = 3'b011; multiplier = 3'b011;
    ndone = 0;
    for (int i = 0; i < MW + 1; i++) begin
      if (done) ndone++;
      if (i < MW) @(negedge clk);
    end
    check("busy_start_product", 32'(product), 32'b00010);
    check("busy_start_one_done", 32'(ndone), 32'd1);
    start = 1'b0;
    @(negedge clk);

    // reset in the second RUN cycle aborts the op
    wait_idle();
    multiplicand = 3'b011; multiplier = 3'b011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {26'd0, product, busy, done, zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);
    run_op("after_abort", 3'b010, 3'b011, 5'b00110, 1'b0);

    // start held high: one op every MW+2 cycles
    wait_idle();
    @(negedge clk);
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) ndone++;
      multiplicand = MW'($urandom);
      multiplier   = MW'($urandom);
    end
    check("held_start_dones", 32'(ndone), 32'd4);
    start = 1'b0;

    // random traffic with occasional reset, checked by the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start        = ($urandom_range(0, 2) != 0);
      multiplicand = ($urandom_range(0, 7));
      multiplier   = ($urandom_range(0, 7));
      rst          = ($urandom_range(0, 39) == 0);
    end
    rst = 1'b0; start = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
